// File: rtl/rr_resp_router.sv
// rr_resp_router: slave-side response return stage.
// Tracks {master_id, cmd} of each granted request in an in-order FIFO and
// steers every slave response back to the master that issued it as a
// registered one-cycle pulse. Raises full so the arbiter holds off grants.
// Optional head-of-line timeout: define RR_RESP_TIMEOUT_EN.
module rr_resp_router #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     perm0,
  input  logic                     perm1,
  input  logic                     cmd_to,
  input  logic                     s_resp,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic                     resp0,
  output logic                     resp1,
  output logic [DATA_W-1:0]        rdata0,
  output logic [DATA_W-1:0]        rdata1,
  output logic                     resp_err,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("rr_resp_router: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  // Tracking storage: bit 1 = master id, bit 0 = cmd (1 = write)
  logic [1:0]        mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              proto_err_q, proto_err_d;
  logic              resp0_q, resp1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              empty, grant, push, push_id, pop_real, pop, pop_to;
  logic              head_id, head_cmd;
  logic [DATA_W-1:0] pop_data;

`ifdef RR_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          resp_err_q;

  // Head-of-line wait counter; a timeout pop stands in for a missing s_resp
  always_comb begin
    pop_to = !empty && !pop_real && (tmr_q == TW'(TIMEOUT));
    tmr_d  = tmr_q;
    if (empty || pop_real || pop_to) tmr_d = '0;
    else                             tmr_d = tmr_q + 1'b1;
  end

  // Timeout counter and error-flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      resp_err_q <= pop_to;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign pop_to   = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign head_id  = mem_q[rd_ptr_q][1];
  assign head_cmd = mem_q[rd_ptr_q][0];

  // Push/pop decisions; full is judged on the pre-pop count, so a grant
  // arriving together with a pop is still taken when the FIFO is full
  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(DEPTH));
    grant    = perm0 | perm1;
    push_id  = perm1 & ~perm0;
    pop_real = s_resp & ~empty;
    pop      = pop_real | pop_to;
    push     = grant & (~full | pop);
    pop_data = (head_cmd || pop_to) ? '0 : s_rdata;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;

    proto_err_d = proto_err_q
                | (perm0 & perm1)
                | (grant & full & ~pop)
                | (s_resp & empty);
  end

  // Entry storage; contents are only meaningful under the count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_id, cmd_to};
  end

  // Pointers, count, sticky error and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
      resp0_q     <= 1'b0;
      resp1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
      resp0_q     <= pop & ~head_id;
      resp1_q     <= pop &  head_id;
      if (pop && !head_id) rdata0_q <= pop_data;
      if (pop &&  head_id) rdata1_q <= pop_data;
    end
  end

  assign resp0       = resp0_q;
  assign resp1       = resp1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign outstanding = cnt_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_rr_resp_router.sv
// Bench for rr_resp_router: table of per-cycle vectors plus hand-written
// reset / protocol-error / timeout sequences; expected responses are queued
// when stimulus is driven and consumed when the pulse is due.
module tb_rr_resp_router;

  logic        clk = 1'b0;
  logic        reset, perm0, perm1, cmd_to, s_resp;
  logic [31:0] s_rdata;
  logic        resp0, resp1, resp_err, full, proto_err;
  logic [31:0] rdata0, rdata1;
  logic [2:0]  outstanding;

  rr_resp_router #(.DEPTH(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .perm0(perm0), .perm1(perm1), .cmd_to(cmd_to),
    .s_resp(s_resp), .s_rdata(s_rdata), .resp0(resp0), .resp1(resp1),
    .rdata0(rdata0), .rdata1(rdata1), .resp_err(resp_err), .full(full),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic p0, p1, cmd, sr;
    logic [31:0] sd;
    int   pulse;            // 0 none, 1 master 0, 2 master 1
    logic [31:0] pd;
    logic [2:0] out;
    logic full, perr;
  } vec_t;

  typedef struct { logic id; logic [31:0] d; logic err; } exp_t;

  vec_t        tbl[$];
  exp_t        exp_q[$];
  logic [31:0] rd0_exp, rd1_exp;
  int          nvec = 0;
  int          nfail = 0;

  function automatic vec_t mk(int p0, int p1, int cmd, int sr, int sd,
                              int pulse, int pd, int out, int f, int pe);
    vec_t v;
    v.p0 = (p0 != 0); v.p1 = (p1 != 0); v.cmd = (cmd != 0); v.sr = (sr != 0);
    v.sd = 32'(sd); v.pulse = pulse; v.pd = 32'(pd);
    v.out = 3'(out); v.full = (f != 0); v.perr = (pe != 0);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive one cycle of stimulus, then check after the edge
  task automatic step(vec_t v, string tag);
    exp_t e;
    perm0 = v.p0; perm1 = v.p1; cmd_to = v.cmd; s_resp = v.sr; s_rdata = v.sd;
    if (v.pulse != 0) begin
      e.id = (v.pulse == 2); e.d = v.pd; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    perm0 = 0; perm1 = 0; cmd_to = 0; s_resp = 0; s_rdata = '0;
    nvec++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " resp0"}, 32'(resp0), 32'(!e.id));
      chk({tag, " resp1"}, 32'(resp1), 32'(e.id));
      chk({tag, " resp_err"}, 32'(resp_err), 32'(e.err));
      if (e.id) rd1_exp = e.d; else rd0_exp = e.d;
    end else begin
      chk({tag, " resp0"}, 32'(resp0), 0);
      chk({tag, " resp1"}, 32'(resp1), 0);
    end
    chk({tag, " rdata0"}, rdata0, rd0_exp);
    chk({tag, " rdata1"}, rdata1, rd1_exp);
    chk({tag, " outstanding"}, 32'(outstanding), 32'(v.out));
    chk({tag, " full"}, 32'(full), 32'(v.full));
    chk({tag, " proto_err"}, 32'(proto_err), 32'(v.perr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    rd0_exp = '0; rd1_exp = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; perm0 = 0; perm1 = 0; cmd_to = 0; s_resp = 0; s_rdata = '0;
    rd0_exp = '0; rd1_exp = '0;

    //          p0 p1 cmd sr sd    pulse pd    out full perr
    // in-order routing
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0,    1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,    0, 0,    2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0,    3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'hA,  1, 'hA,  2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'hB,  2, 0,    1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'hC,  1, 'hC,  0, 0, 0));
    // fill to full, drop a grant, then push+pop while full
    tbl.push_back(mk(0, 1, 0, 0, 0,    0, 0,    1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,    0, 0,    2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,    0, 0,    3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0,    4, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,    0, 0,    4, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 'h11, 2, 'h11, 4, 1, 1));
    // ten push/pop cycles at full to walk the pointers around
    tbl.push_back(mk(0, 1, 0, 1, 'h20, 1, 0,    4, 1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 'h21, 2, 0,    4, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 'h22, 1, 'h22, 4, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 'h23, 1, 'h23, 4, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 'h24, 2, 'h24, 4, 1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 'h25, 1, 0,    4, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 'h26, 2, 0,    4, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 'h27, 1, 'h27, 4, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 'h28, 2, 'h28, 4, 1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 'h29, 1, 0,    4, 1, 1));
    // drain
    tbl.push_back(mk(0, 0, 0, 1, 'h30, 2, 0,    3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 'h31, 1, 'h31, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 'h32, 2, 'h32, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 'h33, 1, 0,    0, 0, 1));

    // reset state
    repeat (2) @(negedge clk);
    nvec++;
    chk("rst outstanding", 32'(outstanding), 0);
    chk("rst full", 32'(full), 0);
    chk("rst resp0", 32'(resp0), 0);
    chk("rst resp1", 32'(resp1), 0);
    chk("rst rdata0", rdata0, 0);
    chk("rst rdata1", rdata1, 0);
    chk("rst resp_err", 32'(resp_err), 0);
    chk("rst proto_err", 32'(proto_err), 0);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // reset in the middle of traffic, with a response pulse live
    do_reset();
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "mid0");
    step(mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0), "mid1");
    step(mk(1, 0, 0, 0, 0, 0, 0, 3, 0, 0), "mid2");
    s_resp = 1'b1; s_rdata = 32'h99;
    @(posedge clk); #1;
    nvec++;
    chk("mid pulse before reset", 32'(resp0), 1);
    reset = 1'b1;
    #1;
    nvec++;
    chk("mid async outstanding", 32'(outstanding), 0);
    chk("mid async full", 32'(full), 0);
    chk("mid async resp0", 32'(resp0), 0);
    chk("mid async resp1", 32'(resp1), 0);
    chk("mid async rdata0", rdata0, 0);
    s_resp = 1'b0; s_rdata = '0;
    exp_q.delete(); rd0_exp = '0; rd1_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    step(mk(0, 0, 0, 1, 'h5A, 0, 0, 0, 0, 1), "mid late s_resp");

    // both grants in one cycle: master 0 only
    do_reset();
    step(mk(1, 1, 0, 0, 0,    0, 0,    1, 0, 1), "both");
    step(mk(0, 0, 0, 1, 'h55, 1, 'h55, 0, 0, 1), "both pop");

    // push and s_resp into an empty FIFO in the same cycle
    do_reset();
    step(mk(0, 1, 0, 1, 'h66, 0, 0,    1, 0, 1), "emptypush");
    step(mk(0, 0, 0, 1, 'h77, 2, 'h77, 0, 0, 1), "emptypush pop");

`ifdef RR_RESP_TIMEOUT_EN
    // head-of-line timeout with TIMEOUT = 8
    begin
      int  waited;
      bit  seen;
      do_reset();
      step(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "to grant");
      waited = 0; seen = 0;
      for (int n = 1; n <= 16 && !seen; n++) begin
        @(negedge clk);
        waited = n;
        if (resp1) seen = 1;
      end
      nvec++;
      if (!seen) begin
        nfail++;
        $display("FAIL timeout pulse: none within %0d cycles, want resp1", waited);
      end else begin
        chk("timeout latency in range", 32'(waited >= 8 && waited <= 10), 1);
        chk("timeout resp_err", 32'(resp_err), 1);
        chk("timeout rdata1", rdata1, 0);
        chk("timeout outstanding", 32'(outstanding), 0);
        chk("timeout resp0", 32'(resp0), 0);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/rr_resp_router.md
Name: rr_resp_router

Overview:
- Slave-side response return stage, one instance per slave, downstream of that slave's round-robin request arbiter.
- Records which master each granted request came from, and its command, in a small in-order FIFO.
- Routes each slave response back to the originating master as a one-cycle response pulse with read data.
- Drives a full flag back to the arbiter so no grant is issued while the tracking FIFO is full.

Parameters:
- DEPTH, 4, outstanding-request tracking entries; power of two, minimum 2.
- DATA_W, 32, read-data width.
- TIMEOUT, 255, cycles the FIFO head may wait for a slave response (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- perm0  input  1  grant to master 0 issued to this slave this cycle (arbiter perm0).
- perm1  input  1  grant to master 1 issued to this slave this cycle (arbiter perm1).
- cmd_to  input  1  command of the granted request; 1 = write, 0 = read.
- s_resp  input  1  slave response strobe, one per completed request, in order.
- s_rdata  input  DATA_W  slave read data, valid with s_resp.
- resp0  output  1  response pulse to master 0.
- resp1  output  1  response pulse to master 1.
- rdata0  output  DATA_W  read data to master 0.
- rdata1  output  DATA_W  read data to master 1.
- resp_err  output  1  response flagged erroneous; valid with resp0/resp1.
- full  output  1  tracking FIFO full; the arbiter must not grant.
- outstanding  output  clog2(DEPTH)+1  number of tracked requests.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, reset=1): pointers and count cleared. resp0, resp1, resp_err, proto_err, full = 0. rdata0, rdata1 = 0. outstanding = 0.
- FIFO entry: {master_id, cmd}.
- Push: on a rising edge with exactly one of perm0/perm1 = 1 and full = 0, write {perm1 ? 1 : 0, cmd_to}.
- Both perm0 and perm1 = 1 in one cycle: push master 0 only, set proto_err.
- Grant while full = 1: grant dropped, no state change, set proto_err.
- Pop: on a rising edge with s_resp = 1 and outstanding > 0, remove the head entry.
  - On the next cycle, pulse resp<id> = 1 for exactly one cycle.
  - Registered latency is 1 cycle from s_resp.
  - rdata<id> = s_rdata for a read, 0 for a write.
  - The other master's rdata holds its previous value.
  - resp_err = 0.
- s_resp while empty: ignored, set proto_err, no response pulse.
- Push and pop in the same cycle:
  - Both take effect; count unchanged.
  - When full, a push in the same cycle as a pop is accepted, because full is evaluated before the pop.
  - When empty, a simultaneous push and s_resp does not pop the new entry; treated as s_resp-while-empty.
- Pointers: log2(DEPTH) bits, wrap DEPTH-1 -> 0.
- full = (outstanding == DEPTH), combinational from the registered count.
- proto_err is cleared only by reset.
- Responses always return in grant order; there is no reordering.

Optional Feature:
- Macro: RR_RESP_TIMEOUT_EN.
- When defined:
  - A counter runs while outstanding > 0 and no pop occurs.
  - It clears on every pop, and on reset.
  - When the count reaches TIMEOUT, the head entry is popped as if s_resp had arrived, and the counter clears.
  - The resulting pulse has resp_err = 1 and rdata = 0.
  - A late real s_resp for that entry pops the next entry; the system accepts this.
- When undefined: no counter, resp_err is tied to 0, and the TIMEOUT parameter is unused.

Test Plan:
- Reset mid-traffic: 3 entries outstanding, assert reset -> outstanding=0, full=0, resp0/1=0 immediately; a later s_resp sets proto_err=1.
- Ordering: grants m0 read, m1 write, m0 read; s_resp with data 0xA, 0xB, 0xC -> resp0 with rdata0=0xA, then resp1 with rdata1=0, then resp0 with rdata0=0xC; each pulse 1 cycle after its s_resp.
- Full and wrap: 4 grants -> full=1; a 5th grant is dropped and sets proto_err; pop 1 and push 1 in the same cycle -> outstanding stays 4. Repeat 10 push/pop cycles to cover pointer wrap; order is preserved.
- Simultaneous perm0=perm1=1 -> one entry with master 0, proto_err=1, outstanding +1.
- Empty-and-push with s_resp in the same cycle -> no response pulse, outstanding=1, proto_err=1.
- With RR_RESP_TIMEOUT_EN, TIMEOUT=8: one grant from m1 and no s_resp -> after 8 cycles resp1=1, resp_err=1, rdata1=0, outstanding=0.
